// File: rtl/divisor_nb.sv
// Front-panel integer divider: enter numerator/denominator with buttons, restoring divide, browse results.
// Define DIVISOR_SATURATE_EN to make the entry counter saturate instead of wrapping.
module divisor_nb #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             ok,
    output logic [WIDTH-1:0] leds,
    output logic [1:0]       phase,
    output logic             busy
);

    localparam int IW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        ENTER_NUM,
        ENTER_DEN,
        DIVIDE,
        SHOW_QUO,
        SHOW_REM
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] num, den, quo, rem;
    logic [WIDTH-1:0] dvd, qacc;
    logic [WIDTH-1:0] part_rem, part_next;
    logic [WIDTH:0]   r_shift;
    logic             q_bit;
    logic [IW-1:0]    iter;
    logic             up_q, down_q, ok_q;
    logic             up_e, down_e, ok_e;
    logic             last_iter;

    assign up_e      = up & ~up_q;
    assign down_e    = down & ~down_q;
    assign ok_e      = ok & ~ok_q;
    assign last_iter = (iter == IW'(WIDTH - 1));

    // The partial remainder is always below den, so WIDTH bits suffice once the shift is taken.
    assign r_shift   = {part_rem, dvd[WIDTH-1]};
    assign q_bit     = (r_shift >= {1'b0, den});
    assign part_next = q_bit ? WIDTH'(r_shift - {1'b0, den}) : r_shift[WIDTH-1:0];

    always_comb begin
        cnt_next = cnt;
        if (up_e && !down_e) begin
`ifdef DIVISOR_SATURATE_EN
            cnt_next = (cnt == '1) ? cnt : cnt + 1'b1;
`else
            cnt_next = cnt + 1'b1;
`endif
        end else if (down_e && !up_e) begin
`ifdef DIVISOR_SATURATE_EN
            cnt_next = (cnt == '0) ? cnt : cnt - 1'b1;
`else
            cnt_next = cnt - 1'b1;
`endif
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ENTER_NUM: if (ok_e) state_next = ENTER_DEN;
            ENTER_DEN: if (ok_e) state_next = DIVIDE;
            DIVIDE:    if (last_iter) state_next = SHOW_QUO;
            SHOW_QUO:  if (ok_e) state_next = SHOW_REM;
            SHOW_REM:  if (ok_e) state_next = ENTER_NUM;
            default:   state_next = ENTER_NUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ENTER_NUM;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            ok_q     <= 1'b0;
            cnt      <= '0;
            num      <= '0;
            den      <= '0;
            quo      <= '0;
            rem      <= '0;
            dvd      <= '0;
            qacc     <= '0;
            part_rem <= '0;
            iter     <= '0;
        end else begin
            up_q   <= up;
            down_q <= down;
            ok_q   <= ok;
            case (state)
                ENTER_NUM: begin
                    if (ok_e) begin
                        num <= cnt;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                ENTER_DEN: begin
                    if (ok_e) begin
                        den      <= cnt;
                        cnt      <= '0;
                        dvd      <= num;
                        qacc     <= '0;
                        part_rem <= '0;
                        iter     <= '0;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                DIVIDE: begin
                    part_rem <= part_next;
                    dvd      <= {dvd[WIDTH-2:0], 1'b0};
                    qacc     <= {qacc[WIDTH-2:0], q_bit};
                    iter     <= iter + 1'b1;
                    if (last_iter) begin
                        quo <= {qacc[WIDTH-2:0], q_bit};
                        rem <= part_next;
                    end
                end
                SHOW_REM: begin
                    if (ok_e) cnt <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        leds  = '0;
        phase = 2'b00;
        busy  = 1'b0;
        case (state)
            ENTER_NUM: begin
                leds  = cnt;
                phase = 2'b00;
            end
            ENTER_DEN: begin
                leds  = cnt;
                phase = 2'b01;
            end
            DIVIDE: begin
                phase = 2'b10;
                busy  = 1'b1;
            end
            SHOW_QUO: begin
                leds  = quo;
                phase = 2'b10;
            end
            SHOW_REM: begin
                leds  = rem;
                phase = 2'b11;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/divisor_nb.md
# divisor_nb

Parametrised interactive integer divider for the board push-button/LED front panel. The user enters a numerator and a denominator with up/down/ok buttons. A sequential restoring divider then computes quotient and remainder, one bit per clock. The user steps through both results on the LEDs with ok. It generalises the fixed 4-bit, stubbed-result divider to any width WIDTH and adds real division, button edge detection, a busy indication and a configurable counter overflow policy.

## Interface
- WIDTH, 4, operand/result/LED width; legal range 2..16
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset
- up  in  1  increment request; level input, synchronous to clk
- down  in  1  decrement request; level input, synchronous to clk
- ok  in  1  confirm/advance request; level input, synchronous to clk
- leds  out  WIDTH  displayed value
- phase  out  2  00 numerator entry, 01 denominator entry, 10 quotient, 11 remainder
- busy  out  1  high while division iterates

## Operation
- Edge detection: each of up/down/ok has a previous-sample register, reset 0. An edge = input 1 now and 0 previously. A held button acts exactly once.
- States: ENTER_NUM, ENTER_DEN, DIVIDE, SHOW_QUO, SHOW_REM. Reset state is ENTER_NUM.
- Entry counter cnt (WIDTH bits, reset 0):
  - Active in ENTER_NUM and ENTER_DEN only.
  - up edge: +1. down edge: −1. up and down edges in the same cycle: no change.
  - Overflow behaviour is set under Configuration.
- ok edge has priority. Any up/down edge in the same cycle is discarded.
  - ENTER_NUM + ok: num <= cnt; cnt <= 0; go to ENTER_DEN.
  - ENTER_DEN + ok: den <= cnt; cnt <= 0; load dividend shift register with num; partial remainder (WIDTH+1 bits) <= 0; iteration count <= 0; go to DIVIDE.
- DIVIDE (restoring, MSB first):
  - Each cycle: R' = {R, next dividend bit}.
  - If R' >= den: R <= R' − den and quotient bit = 1. Otherwise R <= R' and quotient bit = 0.
  - After WIDTH iterations: quo and rem are valid; go to SHOW_QUO.
  - All button edges are ignored in DIVIDE. The previous-sample registers keep updating.
- den = 0: no special case. The algorithm yields quo = all ones and rem = num, and still takes WIDTH cycles.
- SHOW_QUO + ok: go to SHOW_REM.
- SHOW_REM + ok: go to ENTER_NUM with cnt = 0. num/den/quo/rem are held until overwritten.
- up/down in SHOW_QUO and SHOW_REM: ignored.
- leds per state: ENTER_NUM and ENTER_DEN show cnt (live); DIVIDE shows 0; SHOW_QUO shows quo; SHOW_REM shows rem.
- phase per state: ENTER_NUM 00; ENTER_DEN 01; DIVIDE and SHOW_QUO 10; SHOW_REM 11.
- busy = 1 only in DIVIDE.
- Outputs are registered or decoded from registered state only. No combinational path from inputs to outputs.

## Timing
- Reset (rst = 0, asynchronous): state ENTER_NUM; cnt, num, den, quo, rem, R, edge registers all 0. Outputs: leds = 0, phase = 00, busy = 0.
- Reset mid-division aborts immediately. There is no partial result.
- Release of rst takes effect synchronously at the next clk edge.
- A button level first sampled high at edge k (low at k−1) acts at edge k. Its effect is visible on leds/phase after edge k.
- Division latency:
  - ok accepted at edge k enters DIVIDE.
  - Iterations occur at edges k+1 .. k+WIDTH.
  - State is SHOW_QUO after edge k+WIDTH.
  - busy is high for exactly WIDTH cycles.
- A button held from DIVIDE into SHOW_QUO does not generate an edge there.

## Configuration
- DIVISOR_SATURATE_EN defined: cnt saturates. up at 2^WIDTH−1 holds the value; down at 0 holds 0.
- DIVISOR_SATURATE_EN undefined (default): cnt wraps modulo 2^WIDTH. up at max gives 0; down at 0 gives max.
- No other behaviour differs.

## Test plan
- WIDTH=4: enter 13 (13 up pulses), ok, enter 4, ok → busy high for 4 cycles. Then phase=10 with leds=3; ok → phase=11 with leds=1; ok → phase=00 with leds=0.
- WIDTH=4: num 7, den 0 → quo 15, rem 7; latency still 4 cycles.
- WIDTH=4, macro undefined: down edge at cnt=0 → leds=15. Macro defined: leds stays 0; 16 up edges → leds stays 15.
- ok held high for 10 cycles in ENTER_NUM → exactly one advance, to phase=01. up and down rising on the same cycle → cnt unchanged. up and ok edges on the same cycle → advance only, cnt=0.
- rst asserted 2 cycles into DIVIDE (WIDTH=8, 200/7) → asynchronously leds=0, phase=00, busy=0. A following full run yields quo 28, rem 4.
- WIDTH=8: 255/1 → quo 255, rem 0, busy for 8 cycles.
